// File: rtl/mul32_seq_pkg.sv
// Shared state encoding and iteration constants for the sequential 32x32 multiplier.
package mul32_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int ITER  = 32;
    localparam int CNT_W = 5;

    // Count value of the final CALC iteration.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

endpackage

// File: rtl/mul32_seq_if.sv
// Start/busy/done handshake plus operand and product buses between issuer and multiplier.
interface mul32_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    modport master (output start, output a, output b,
                    input  busy,  input  done, input product);
    modport slave  (input  start, input  a, input b,
                    output busy,  output done, output product);
endinterface

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group carry.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = ci;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (&p[4*k +: 4] & c[4*k]);
        end
    end

    assign s  = p ^ c[31:0];
    assign co = c[32];
endmodule

// File: rtl/mul32_seq.sv
// Sequential unsigned 32x32->64 shift-add multiplier: one cla32 addition per cycle for 32 cycles.
module mul32_seq
    import mul32_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mul32_seq_if.slave bus
);
    state_t           state_q, state_d;
    logic [31:0]      mcand_q, mcand_d;
    logic [31:0]      acc_hi_q, acc_hi_d;
    logic [31:0]      acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      product_q, product_d;

    logic [31:0] addend;
    logic [31:0] sum;
    logic        co;
    logic        accept;
    logic        last;

    assign addend = acc_lo_q[0] ? mcand_q : 32'd0;
    assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);
    assign last   = (count_q == LAST_CNT);

    cla32 u_add (
        .a  (acc_hi_q),
        .b  (addend),
        .ci (1'b0),
        .s  (sum),
        .co (co)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_CALC;
            S_CALC:  if (last) state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == S_CALC);
        bus.done = (state_q == S_DONE);
    end

    assign bus.product = product_q;

    // Datapath: load on accepted start, shift the accumulator right once per CALC cycle.
    always_comb begin
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        count_d   = count_q;
        product_d = product_q;
        if (accept) begin
            mcand_d  = bus.a;
            acc_lo_d = bus.b;
            acc_hi_d = 32'd0;
            count_d  = '0;
        end else if (state_q == S_CALC) begin
            acc_hi_d = {co, sum[31:1]};
            acc_lo_d = {sum[0], acc_lo_q[31:1]};
            count_d  = count_q + 1'b1;
            if (last) begin
                product_d = {co, sum, acc_lo_q[31:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end
endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: vector table, scoreboard queue and handshake corner cases.
module tb_mul32_seq;
    logic clk = 1'b0;
    logic reset;

    mul32_seq_if bus ();

    mul32_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs [10];
    logic [63:0] sb [$];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Waits for done, counting cycles after the accept edge; optionally pulses a stray start at cycle inj.
    task automatic wait_done(input int inj, output int cyc, output int bsy, output bit got);
        cyc = 0;
        bsy = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) bsy++;
            if (bus.done) got = 1'b1;
            if (cyc == inj) begin
                bus.start = 1'b1;
                bus.a     = 32'd9;
                bus.b     = 32'd9;
            end else if (cyc == inj + 1) begin
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic check_op(input string nm, input int inj);
        int          cyc, bsy;
        bit          got;
        logic [63:0] e;
        wait_done(inj, cyc, bsy, got);
        chk({nm, " done_seen"}, 64'(got), 64'd1);
        chk({nm, " latency"}, 64'(cyc), 64'd33);
        chk({nm, " busy_cycles"}, 64'(bsy), 64'd32);
        e = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        chk({nm, " product"}, bus.product, e);
        @(negedge clk);
        chk({nm, " done_one_cycle"}, 64'(bus.done), 64'd0);
        chk({nm, " product_held"}, bus.product, e);
    endtask

    initial begin
        int          cyc, bsy, dn;
        bit          got;
        logic [63:0] e;

        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, "3x5"};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, "max_x_max"};
        vecs[2] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000, "msb_x_2"};
        vecs[3] = '{32'd0,          32'h1234_5678,  64'd0,                   "zero_x_b"};
        vecs[4] = '{32'h1234_5678,  32'd0,          64'd0,                   "a_x_zero"};
        vecs[5] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF, "1_x_max"};
        vecs[6] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF, "max_x_1"};
        vecs[7] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, "2p16_sq"};
        vecs[8] = '{32'd7,          32'd6,          64'd42,                  "7x6"};
        vecs[9] = '{32'hDEAD_BEEF,  32'h1234_5678,  64'd0,                   "mixed"};
        vecs[9].exp = {32'd0, vecs[9].a} * {32'd0, vecs[9].b};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset product", bus.product, 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            check_op(vecs[i].name, -1);
        end

        // Stray start during CALC must be ignored.
        issue(32'd7, 32'd6, 64'd42, 1'b1);
        check_op("ignore_start", 10);

        // Reset at CALC cycle 15 aborts without a done pulse.
        issue(32'd7, 32'd6, 64'd0, 1'b0);
        dn = 0;
        repeat (14) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        @(negedge clk);
        if (bus.done) dn++;
        reset = 1'b1;
        @(negedge clk);
        chk("abort no_done", 64'(dn), 64'd0);
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort done", 64'(bus.done), 64'd0);
        chk("abort product", bus.product, 64'd0);
        reset = 1'b0;
        issue(32'd2, 32'd2, 64'd4, 1'b1);
        check_op("after_abort", -1);

        // Back-to-back: start held, second operands presented in the DONE cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd10;
        bus.b     = 32'd10;
        sb.push_back(64'd100);
        @(posedge clk);
        wait_done(-1, cyc, bsy, got);
        chk("b2b first done_seen", 64'(got), 64'd1);
        chk("b2b first latency", 64'(cyc), 64'd33);
        e = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        chk("b2b first product", bus.product, e);
        bus.a = 32'd11;
        bus.b = 32'd11;
        sb.push_back(64'd121);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b no_idle busy", 64'(bus.busy), 64'd1);
        chk("b2b hold product", bus.product, 64'd100);
        wait_done(-1, cyc, bsy, got);
        chk("b2b second done_seen", 64'(got), 64'd1);
        chk("b2b second latency", 64'(cyc + 1), 64'd33);
        e = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        chk("b2b second product", bus.product, e);
        @(negedge clk);
        chk("b2b idle after", 64'(bus.busy | bus.done), 64'd0);
        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
